// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the memory-stage access controller.
package mem_ctrl_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_MAX_WAIT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_RD   = 2'd1,
    OP_WR   = 2'd2
  } op_t;

endpackage

// File: rtl/mem_access_ctrl_wait_timer.sv
// Wait-phase cycle counter: cleared outside WAIT, counts up while enabled,
// terminal count flags when the count has reached MAX_WAIT.
module wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !tc) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc = (cnt_q == CW'(MAX_WAIT));

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: one outstanding single-word access with
// stall/done handshake and timeout. MEM_ACCESS_ALIGN_CHECK_EN rejects odd addresses.
//
// state | meaning
// IDLE  | no access in flight; may start a new one
// REQ   | request driven to memory until accepted (mem_stall=0)
// WAIT  | accepted, waiting for mem_done; timer running
// DONE  | access finished; complete pulse, back to IDLE
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT,
  parameter int DATA_W   = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              flush,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [DATA_W-1:0] aluOut,
  input  logic [DATA_W-1:0] outData,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic              mem_stall,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] memOut,
  output logic              complete,
  output logic              stall,
  output logic              err
);

  state_t state_q, state_d;
  op_t    op_q;
  logic   err_q, err_d;
  logic   start, illegal, misalign, accept;
  logic   capture, timeout, tc;

  wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (state_q != WAIT),
    .en  (state_q == WAIT),
    .tc  (tc)
  );

  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    timeout  = 1'b0;
    start    = valid && (memRead || memWrite) && !flush && (state_q == IDLE);
    illegal  = start && memRead && memWrite;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    misalign = start && aluOut[0];
`else
    misalign = 1'b0;
`endif
    accept   = start && !illegal && !misalign;
    err_d    = illegal || misalign;

    case (state_q)
      IDLE: if (accept) state_d = REQ;
      REQ: begin
        if (!mem_stall) begin
          state_d = mem_done ? DONE : WAIT;
          capture = mem_done && (op_q == OP_RD);
        end
      end
      WAIT: begin
        // a done arriving in the terminal-count cycle still completes
        if (mem_done) begin
          state_d = DONE;
          capture = (op_q == OP_RD);
        end else if (tc) begin
          state_d = IDLE;
          timeout = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= OP_NONE;
      err_q     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      memOut    <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (accept) begin
        mem_addr  <= aluOut;
        mem_wdata <= outData;
        op_q      <= memWrite ? OP_WR : OP_RD;
      end
      if (capture) memOut <= mem_rdata;
    end
  end

  assign stall    = start || (state_q == REQ) || (state_q == WAIT);
  assign mem_rd   = (state_q == REQ) && (op_q == OP_RD);
  assign mem_wr   = (state_q == REQ) && (op_q == OP_WR);
  assign complete = (state_q == DONE);
  assign err      = err_q || timeout;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: IDLE decision table, directed and
// randomized accesses against a cycle-arithmetic timing model, reset and alignment cases.
module tb_mem_access_ctrl;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid, flush, memRead, memWrite;
  logic [15:0] aluOut, outData, mem_addr, mem_wdata, mem_rdata, memOut;
  logic        mem_rd, mem_wr, mem_stall, mem_done, complete, stall, err;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_mo;

  mem_access_ctrl #(.MAX_WAIT(MW), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .valid(valid), .flush(flush),
    .memRead(memRead), .memWrite(memWrite), .aluOut(aluOut), .outData(outData),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_stall(mem_stall), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .memOut(memOut), .complete(complete), .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One access with a reactive memory: stalls s request cycles, then signals
  // done in the same cycle (d==0) or in the d-th WAIT cycle; d > MW+1 never completes.
  task automatic run_acc(input string nm, input bit is_wr, input logic [15:0] a,
                         input logic [15:0] wd, input logic [15:0] rdv,
                         input int s, input int d);
    int t_done = -1, t_err = -1, n_req = 0, n_cpl = 0, n_err = 0, n_stl = 0;
    int reqc = 0, w = 0, exp_done, exp_err, exp_stl, ncyc;
    bit acc = 0, fin = 0, req_ok = 1, tmo;
    tmo      = (d > MW + 1);
    exp_done = tmo ? -1 : (d == 0 ? s + 3 : s + 3 + d);
    exp_err  = tmo ? s + 3 + MW : -1;
    exp_stl  = tmo ? s + MW + 3 : exp_done - 1;
    ncyc     = s + MW + 8;
    valid = 1'b1; flush = 1'b0; memRead = !is_wr; memWrite = is_wr;
    aluOut = a; outData = wd; mem_rdata = rdv;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      if (cyc == 2) begin valid = 1'b0; memRead = 1'b0; memWrite = 1'b0; end
      mem_stall = 1'b0; mem_done = 1'b0;
      if (!fin) begin
        if (mem_rd || mem_wr) begin
          mem_stall = (reqc < s);
          mem_done  = !mem_stall && (d == 0);
        end else if (acc) begin
          w++;
          mem_done = (w == d);
        end
      end
      @(negedge clk);
      if (stall) n_stl++;
      if (mem_rd || mem_wr) begin
        n_req++; reqc++;
        if (mem_addr !== a || mem_rd !== !is_wr || mem_wr !== is_wr) req_ok = 0;
        if (is_wr && mem_wdata !== wd) req_ok = 0;
        if (!mem_stall) acc = 1;
      end
      if (complete) begin n_cpl++; if (t_done < 0) t_done = cyc; fin = 1; end
      if (err) begin n_err++; if (t_err < 0) t_err = cyc; fin = 1; end
      @(posedge clk); #1;
    end
    mem_stall = 1'b0; mem_done = 1'b0;
    if (!is_wr && !tmo) exp_mo = rdv;
    chk({nm, "_done_cycle"}, 32'(t_done), 32'(exp_done));
    chk({nm, "_err_cycle"},  32'(t_err),  32'(exp_err));
    chk({nm, "_req_cycles"}, 32'(n_req),  32'(s + 1));
    chk({nm, "_req_fields"}, 32'(req_ok), 32'd1);
    chk({nm, "_n_complete"}, 32'(n_cpl),  tmo ? 32'd0 : 32'd1);
    chk({nm, "_n_err"},      32'(n_err),  tmo ? 32'd1 : 32'd0);
    chk({nm, "_stall_cycles"}, 32'(n_stl), 32'(exp_stl));
    chk({nm, "_memOut"},     32'(memOut), 32'(exp_mo));
  endtask

  typedef struct {
    bit v, f, r, w;
    logic [15:0] a;
    bit e_stall, e_err, e_req;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          wr_r;
    int          s_r, d_r, sel;
    logic [15:0] a_r, wd_r, rd_r;
    int          n_cpl;

    valid = 0; flush = 0; memRead = 0; memWrite = 0; aluOut = '0; outData = '0;
    mem_stall = 0; mem_done = 0; mem_rdata = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_memOut", 32'(memOut), 32'd0);
    chk("rst_complete", 32'(complete), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    exp_mo = '0;

    //        v  f  r  w  addr        stall err req
    tbl[0] = '{0, 0, 1, 0, 16'h0010, 0, 0, 0};
    tbl[1] = '{1, 0, 0, 0, 16'h0010, 0, 0, 0};
    tbl[2] = '{1, 0, 1, 1, 16'h0012, 1, 1, 0};
    tbl[3] = '{1, 1, 1, 0, 16'h0014, 0, 0, 0};
    tbl[4] = '{1, 1, 1, 1, 16'h0016, 0, 0, 0};
    tbl[5] = '{1, 0, 1, 0, 16'h0018, 1, 0, 1};
    tbl[6] = '{1, 0, 0, 1, 16'h0022, 1, 0, 1};
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    tbl[7] = '{1, 0, 1, 0, 16'h0033, 1, 1, 0};
`else
    tbl[7] = '{1, 0, 1, 0, 16'h0033, 1, 0, 1};
`endif

    for (int i = 0; i < 8; i++) begin
      valid = tbl[i].v; flush = tbl[i].f; memRead = tbl[i].r; memWrite = tbl[i].w;
      aluOut = tbl[i].a; outData = 16'hC000 + 16'(i);
      mem_stall = 0; mem_done = 0; mem_rdata = 16'h5A00 + 16'(i);
      @(negedge clk);
      chk($sformatf("tbl%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
      @(posedge clk); #1;
      valid = 0; flush = 0; memRead = 0; memWrite = 0;
      @(negedge clk);
      chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].e_err));
      chk($sformatf("tbl%0d_req", i), 32'(mem_rd | mem_wr), 32'(tbl[i].e_req));
      if (tbl[i].e_req && tbl[i].r) exp_mo = 16'h5A00 + 16'(i);
      if (mem_rd || mem_wr) begin
        mem_done = 1'b1;
        @(posedge clk); #1 mem_done = 1'b0;
        @(negedge clk);
        chk($sformatf("tbl%0d_complete", i), 32'(complete), 32'd1);
      end
      repeat (MW + 3) @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_memOut", i), 32'(memOut), 32'(exp_mo));
    end

    run_acc("load0", 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 0, 0);
    run_acc("store_bp", 1'b1, 16'h0100, 16'h1234, 16'hFFFF, 2, 3);
    run_acc("timeout", 1'b0, 16'h0300, 16'h0000, 16'hAAAA, 0, 99);
    run_acc("done_wins", 1'b0, 16'h0302, 16'h0000, 16'h7777, 1, MW + 1);
`ifndef MEM_ACCESS_ALIGN_CHECK_EN
    run_acc("odd_addr", 1'b0, 16'h0041, 16'h0000, 16'h4141, 0, 1);
`endif

    for (int k = 0; k < 30; k++) begin
      wr_r = 1'($urandom_range(0, 1));
      a_r  = 16'($urandom) & 16'hFFFE;
      wd_r = 16'($urandom);
      rd_r = 16'($urandom);
      s_r  = $urandom_range(0, 3);
      sel  = $urandom_range(0, 6);
      d_r  = (sel == 6) ? 99 : sel;
      run_acc($sformatf("rnd%0d", k), wr_r, a_r, wd_r, rd_r, s_r, d_r);
    end

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    valid = 1; memRead = 1; aluOut = 16'h0041;
    @(posedge clk); #1 valid = 0; memRead = 0;
    @(negedge clk);
    chk("align_err", 32'(err), 32'd1);
    chk("align_no_rd", 32'(mem_rd), 32'd0);
    @(posedge clk); #1;
`endif

    // reset while an access is waiting in WAIT
    mem_rdata = 16'h9999; mem_stall = 0; mem_done = 0;
    valid = 1; memRead = 1; aluOut = 16'h0200;
    @(posedge clk); #1 valid = 0; memRead = 0;
    @(posedge clk); #1;
    chk("rstwait_stall_before", 32'(stall), 32'd1);
    #2 rst = 1'b1;
    #1;
    exp_mo = '0;
    chk("rstwait_mem_rd", 32'(mem_rd), 32'd0);
    chk("rstwait_mem_addr", 32'(mem_addr), 32'd0);
    chk("rstwait_memOut", 32'(memOut), 32'(exp_mo));
    chk("rstwait_stall", 32'(stall), 32'd0);
    chk("rstwait_err", 32'(err), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    mem_done = 1'b1; mem_rdata = 16'hDEAD;
    n_cpl = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (complete) n_cpl++;
      @(posedge clk); #1 mem_done = 1'b0;
    end
    chk("rstwait_late_done_complete", 32'(n_cpl), 32'd0);
    chk("rstwait_late_done_memOut", 32'(memOut), 32'(exp_mo));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
